// File: rtl/ad9866_pkg.sv
// Shared types and constants for the AD9866 serial-port responder.
// Register reset image, frame bit positions and FSM state encoding.
package ad9866_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_INSTR = 2'd1,
      ST_DATA  = 2'd2,
      ST_WAIT  = 2'd3
   } ad9866_state_e;

   localparam int AD9866_NREGS = 20;

   // Element 0 is the leftmost byte of the concatenation.
   localparam logic [0:AD9866_NREGS-1][7:0] AD9866_REG_RESET = {8'h80, {(AD9866_NREGS-1){8'h00}}};

   localparam logic [4:0] AD9866_ADDR_RXGAIN = 5'h0A;

   localparam int AD9866_FRAME_W  = 16;
   localparam int AD9866_RW_BIT   = 15;
   localparam int AD9866_ADDR_HI  = 12;
   localparam int AD9866_ADDR_LO  = 8;

endpackage

// File: rtl/ad9866_regfile.sv
// AD9866 shadow register file: one synchronous write port, one asynchronous
// read port and a fixed tap on the RX gain register.
module ad9866_regfile
   import ad9866_pkg::*;
#(
   parameter int                          NREGS        = AD9866_NREGS,
   parameter logic [0:NREGS-1][7:0]       RESET_VALUES = AD9866_REG_RESET
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       we,
   input  logic [4:0] waddr,
   input  logic [7:0] wdata,
   input  logic [4:0] raddr,
   output logic [7:0] rdata,
   output logic [5:0] rx_gain
);

   localparam logic [5:0] NREGS_L = 6'(NREGS);

   logic [7:0] regs [0:NREGS-1];
   logic       raddr_ok;

   assign raddr_ok = ({1'b0, raddr} < NREGS_L);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= RESET_VALUES[i];
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   // Unimplemented addresses read back as zero.
   always_comb begin
      rdata = 8'h00;
      if (raddr_ok) begin
         rdata = regs[raddr];
      end
   end

   assign rx_gain = regs[AD9866_ADDR_RXGAIN][5:0];

endmodule

// File: rtl/ad9866_spi_responder.sv
// AD9866 4-wire serial port slave: decodes 16-bit frames from an initiator
// sharing clk, updates the shadow registers and drives read data on sdo.
module ad9866_spi_responder
   import ad9866_pkg::*;
#(
   parameter int                    NREGS        = AD9866_NREGS,
   parameter logic [0:NREGS-1][7:0] RESET_VALUES = AD9866_REG_RESET
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       sclk,
   input  logic       sen_n,
   input  logic       sdio,
   output logic       sdo,
   output logic       reg_wr,
   output logic [4:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic [5:0] rx_gain,
   output logic       frame_err,
   output logic       busy
);

   localparam logic [5:0] NREGS_L = 6'(NREGS);
   localparam int         RW_POS  = AD9866_RW_BIT - 8;
   localparam int         AHI_POS = AD9866_ADDR_HI - 8;
   localparam int         ALO_POS = AD9866_ADDR_LO - 8;

   ad9866_state_e state_q, state_d;

   logic       sclk_q;
   logic       rise, fall;
   logic [3:0] bit_cnt_q;
   logic [6:0] shift_q;
   logic [7:0] byte_in;
   logic       rw_q;
   logic [4:0] addr_q;
   logic       addr_ok;
   logic [7:0] rd_data;

   logic       shift_en;
   logic       cnt_clr;
   logic       instr_done;
   logic       frame_done;
   logic       abort;
   logic       sdo_load;
   logic       wr_en;

   logic       sdo_q;
   logic       reg_wr_q;
   logic [4:0] reg_addr_q;
   logic [7:0] reg_wdata_q;
   logic       frame_err_q;
   logic       busy_q;

   assign rise    = sclk & ~sclk_q;
   assign fall    = ~sclk & sclk_q;
   // The bit being shifted in this cycle completes the current byte.
   assign byte_in = {shift_q, sdio};
   assign addr_ok = ({1'b0, addr_q} < NREGS_L);
   assign wr_en   = frame_done & ~rw_q & addr_ok;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // sen_n high takes priority over any sclk edge in the same cycle.
   always_comb begin
      state_d    = state_q;
      shift_en   = 1'b0;
      cnt_clr    = 1'b0;
      instr_done = 1'b0;
      frame_done = 1'b0;
      abort      = 1'b0;
      sdo_load   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!sen_n) begin
               state_d = ST_INSTR;
               cnt_clr = 1'b1;
            end
         end
         ST_INSTR: begin
            if (sen_n) begin
               abort   = 1'b1;
               state_d = ST_IDLE;
            end else if (rise) begin
               shift_en = 1'b1;
               if (bit_cnt_q == 4'd7) begin
                  instr_done = 1'b1;
                  state_d    = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (sen_n) begin
               abort   = 1'b1;
               state_d = ST_IDLE;
            end else if (rise) begin
               shift_en = 1'b1;
               if (bit_cnt_q == 4'd15) begin
                  frame_done = 1'b1;
                  state_d    = ST_WAIT;
               end
            end else if (fall && rw_q) begin
               sdo_load = 1'b1;
            end
         end
         ST_WAIT: begin
            if (sen_n) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_q      <= 1'b0;
         bit_cnt_q   <= 4'd0;
         sdo_q       <= 1'b0;
         reg_wr_q    <= 1'b0;
         reg_addr_q  <= 5'd0;
         reg_wdata_q <= 8'd0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         sclk_q      <= sclk;
         frame_err_q <= abort;
         reg_wr_q    <= wr_en;
         busy_q      <= (state_d != ST_IDLE);
         if (cnt_clr) begin
            bit_cnt_q <= 4'd0;
         end else if (shift_en) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
         end
         // Data bit index is 15 - bit_cnt for counts 8..15, i.e. ~bit_cnt[2:0].
         if (abort || frame_done || cnt_clr) begin
            sdo_q <= 1'b0;
         end else if (sdo_load) begin
            sdo_q <= rd_data[~bit_cnt_q[2:0]];
         end
         if (wr_en) begin
            reg_addr_q  <= addr_q;
            reg_wdata_q <= byte_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (shift_en) begin
         shift_q <= byte_in[6:0];
      end
      if (instr_done) begin
         rw_q   <= byte_in[RW_POS];
         addr_q <= byte_in[AHI_POS:ALO_POS];
      end
   end

   ad9866_regfile #(
      .NREGS        (NREGS),
      .RESET_VALUES (RESET_VALUES)
   ) u_regfile (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (wr_en),
      .waddr   (addr_q),
      .wdata   (byte_in),
      .raddr   (addr_q),
      .rdata   (rd_data),
      .rx_gain (rx_gain)
   );

   assign sdo       = sdo_q;
   assign reg_wr    = reg_wr_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_ad9866_spi_responder.sv
// Directed bench for ad9866_spi_responder: drives 16-bit frames with sclk
// toggling every clk and checks strobes, read data and register contents.
module tb_ad9866_spi_responder;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       sclk = 1'b0;
   logic       sen_n = 1'b1;
   logic       sdio = 1'b0;
   logic       sdo;
   logic       reg_wr;
   logic [4:0] reg_addr;
   logic [7:0] reg_wdata;
   logic [5:0] rx_gain;
   logic       frame_err;
   logic       busy;

   int total = 0;
   int bad   = 0;

   ad9866_spi_responder dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .sclk      (sclk),
      .sen_n     (sen_n),
      .sdio      (sdio),
      .sdo       (sdo),
      .reg_wr    (reg_wr),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .rx_gain   (rx_gain),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask

   // Drives nbits of word MSB first; nbits < 16 ends the frame early (abort).
   // rd holds sdo as seen while sclk is high before each rising edge.
   task automatic frame(input logic [15:0] word, input int nbits,
                        output logic [15:0] rd, output logic wr_seen,
                        output logic wr_after, output logic err_seen);
      rd = 16'h0000;
      @(negedge clk);
      sen_n = 1'b0;
      sclk  = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         sclk = 1'b0;
         sdio = word[15-i];
         @(negedge clk);
         rd[15-i] = sdo;
         sclk = 1'b1;
      end
      @(negedge clk);
      wr_seen = reg_wr;
      sclk  = 1'b0;
      sen_n = 1'b1;
      @(negedge clk);
      wr_after = reg_wr;
      err_seen = frame_err;
      @(negedge clk);
      sdio = 1'b0;
   endtask

   logic [15:0] rd;
   logic        wr_seen, wr_after, err_seen;

   logic [15:0] cfg_w [0:6] = '{16'h0721, 16'h084B, 16'h0B20, 16'h0C41, 16'h0D01, 16'h1100, 16'h0A15};
   logic [4:0]  cfg_a [0:6] = '{5'h00, 5'h07, 5'h08, 5'h0B, 5'h0C, 5'h0D, 5'h11};
   logic [7:0]  cfg_d [0:6] = '{8'h80, 8'h21, 8'h4B, 8'h20, 8'h41, 8'h01, 8'h00};

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_sdo",       16'(sdo),       16'h0000);
      chk("rst_reg_wr",    16'(reg_wr),    16'h0000);
      chk("rst_frame_err", 16'(frame_err), 16'h0000);
      chk("rst_busy",      16'(busy),      16'h0000);
      chk("rst_reg_addr",  16'(reg_addr),  16'h0000);
      chk("rst_reg_wdata", 16'(reg_wdata), 16'h0000);
      chk("rst_rx_gain",   16'(rx_gain),   16'h0000);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      frame(16'h8000, 16, rd, wr_seen, wr_after, err_seen);
      chk("rd00_reset", rd, 16'h0080);
      chk("rd00_no_wr", 16'(wr_seen), 16'h0000);

      frame(16'h0721, 16, rd, wr_seen, wr_after, err_seen);
      chk("wr07_strobe",  16'(wr_seen),   16'h0001);
      chk("wr07_addr",    16'(reg_addr),  16'h0007);
      chk("wr07_wdata",   16'(reg_wdata), 16'h0021);
      chk("wr07_onecyc",  16'(wr_after),  16'h0000);
      chk("wr07_sdo_low", rd,             16'h0000);
      chk("wr07_busy",    16'(busy),      16'h0000);
      frame(16'h8700, 16, rd, wr_seen, wr_after, err_seen);
      chk("rd07", rd, 16'h0021);

      frame(16'h0A2A, 16, rd, wr_seen, wr_after, err_seen);
      chk("wr0a_rx_gain", 16'(rx_gain), 16'h002A);
      frame(16'h8A00, 16, rd, wr_seen, wr_after, err_seen);
      chk("rd0a", rd, 16'h002A);

      frame(16'h0B20, 10, rd, wr_seen, wr_after, err_seen);
      chk("abort_err",      16'(err_seen),  16'h0001);
      chk("abort_no_wr",    16'(wr_seen | wr_after), 16'h0000);
      chk("abort_err_1cyc", 16'(frame_err), 16'h0000);
      chk("abort_addr",     16'(reg_addr),  16'h000A);
      frame(16'h8B00, 16, rd, wr_seen, wr_after, err_seen);
      chk("abort_rd0b", rd, 16'h0000);

      frame(16'h1F55, 16, rd, wr_seen, wr_after, err_seen);
      chk("oor1f_no_wr", 16'(wr_seen),   16'h0000);
      chk("oor1f_wdata", 16'(reg_wdata), 16'h002A);
      frame(16'h9F00, 16, rd, wr_seen, wr_after, err_seen);
      chk("oor1f_rd", rd, 16'h0000);
      frame(16'h1499, 16, rd, wr_seen, wr_after, err_seen);
      chk("oor14_no_wr", 16'(wr_seen), 16'h0000);
      frame(16'h1377, 16, rd, wr_seen, wr_after, err_seen);
      chk("wr13_strobe", 16'(wr_seen), 16'h0001);
      frame(16'h9300, 16, rd, wr_seen, wr_after, err_seen);
      chk("rd13", rd, 16'h0077);

      // Reset in the middle of a frame after five bits.
      @(negedge clk);
      sen_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         sclk = 1'b0;
         sdio = 1'b1;
         @(negedge clk);
         sclk = 1'b1;
      end
      @(negedge clk);
      chk("mid_busy", 16'(busy), 16'h0001);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_busy",   16'(busy),      16'h0000);
      chk("mid_rst_addr",   16'(reg_addr),  16'h0000);
      chk("mid_rst_wdata",  16'(reg_wdata), 16'h0000);
      chk("mid_rst_rxgain", 16'(rx_gain),   16'h0000);
      chk("mid_rst_sdo",    16'(sdo),       16'h0000);
      chk("mid_rst_err",    16'(frame_err | reg_wr), 16'h0000);
      @(negedge clk);
      sclk  = 1'b0;
      sen_n = 1'b1;
      sdio  = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      frame(16'h0C41, 16, rd, wr_seen, wr_after, err_seen);
      chk("post_rst_wr",    16'(wr_seen),   16'h0001);
      chk("post_rst_addr",  16'(reg_addr),  16'h000C);
      chk("post_rst_wdata", 16'(reg_wdata), 16'h0041);
      frame(16'h8C00, 16, rd, wr_seen, wr_after, err_seen);
      chk("post_rst_rd0c", rd, 16'h0041);
      frame(16'h9300, 16, rd, wr_seen, wr_after, err_seen);
      chk("post_rst_rd13", rd, 16'h0000);

      // Configuration sequence as issued by the initiator with gain 0x15.
      for (int i = 0; i < 7; i++) begin
         frame(cfg_w[i], 16, rd, wr_seen, wr_after, err_seen);
         chk($sformatf("cfg_wr_%0d", i), 16'({wr_seen, err_seen}), 16'h0002);
      end
      for (int i = 0; i < 7; i++) begin
         frame({3'b100, cfg_a[i], 8'h00}, 16, rd, wr_seen, wr_after, err_seen);
         chk($sformatf("cfg_rd_%02h", cfg_a[i]), rd, {8'h00, cfg_d[i]});
      end
      chk("cfg_rx_gain", 16'(rx_gain), 16'h0015);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ad9866_spi_responder.md
# ad9866_spi_responder

Synthesizable SPI responder that implements the AD9866 4-wire serial register port inside the FPGA fabric. It is the slave end of the AD9866 configuration link. It runs on the same clock as the configuration initiator and decodes its 16-bit frames into a shadow register file. Write strobes and the RX gain code are presented to fabric logic, and register contents are returned on `sdo` for read frames. Uses: closed-loop bench of the configuration master, and a drop-in stand-in when no AD9866 is fitted.

## Interface
Parameters:
- `NREGS`, 20: number of implemented registers, addresses 0x00..NREGS-1.
- `RESET_VALUES`, `AD9866_REG_RESET` (package): reset contents, indexed by address.

Ports:
- `clk`  in  1  system clock; also the clock of the initiator.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sclk`  in  1  SPI clock from the initiator, same clock domain.
- `sen_n`  in  1  frame enable, active low.
- `sdio`  in  1  serial data in, MSB first.
- `sdo`  out  1  serial read data.
- `reg_wr`  out  1  one-cycle write strobe.
- `reg_addr`  out  5  address of the last write.
- `reg_wdata`  out  8  data of the last write.
- `rx_gain`  out  6  register 0x0A[5:0].
- `frame_err`  out  1  one-cycle pulse on an aborted frame.
- `busy`  out  1  high while a frame is in progress.

## Operation
- Frame layout, 16 bits MSB first: bit15 R/W (1 = read), bits14:13 W1:W0 (ignored), bits12:8 address, bits7:0 data.
- Inputs are used directly, with no synchronizers. `sclk_q` is a registered copy of `sclk`.
  - Rising edge: `sclk & !sclk_q`.
  - Falling edge: `!sclk & sclk_q`.
- FSM states: IDLE, INSTR, DATA, WAIT.
  - IDLE: a sampled `sen_n`=0 moves to INSTR, clears the bit counter and sets `busy`.
  - INSTR: each rising edge shifts `sdio` into the shift register. After the 8th rising edge, latch R/W and address, then go to DATA.
  - DATA, read: on the falling edge after the 8th bit, `sdo` takes data[7]. Each following falling edge advances to the next bit. Data is taken from the register file, or 0x00 if address >= NREGS.
  - DATA, write: the 16th rising edge completes the frame.
  - WAIT: after 16 rising edges, further `sclk` edges are ignored. `sen_n`=1 returns to IDLE and clears `busy`.
- Write commit happens in the cycle after the 16th rising edge:
  - register[addr] is updated;
  - `reg_wr`=1 for one cycle;
  - `reg_addr` and `reg_wdata` update and hold until the next write.
  - If address >= NREGS: no update and no `reg_wr`.
- Abort: `sen_n` sampled high in INSTR or DATA gives:
  - `frame_err` for one cycle;
  - no register write;
  - `sdo` forced to 0;
  - return to IDLE.
- If `sen_n`=1 and a rising edge occur in the same cycle, `sen_n` wins: the edge is not shifted and the frame is treated as an abort.
- `sdo` is 0 outside the DATA phase of a read frame.

## Timing
- Minimum `sclk` high and low time is 1 clk. The initiator toggles `sclk` every clk, and the design must work at that rate.
- Read data: `sdo` is registered on the falling-edge detect and is valid before the next rising `sclk` sample. The initiator captures bit i of its 16-bit shift in at the cycle where it sees `sclk`=1.
- A read frame returns 0x00 in bits 15:8 and the register data in bits 7:0.
- Write latency: `reg_wr` is asserted 1 clk after the cycle in which the 16th rising edge is detected. `rx_gain` follows a write to 0x0A in that same cycle.
- Back-to-back frames need `sen_n` high for at least 1 clk between them.
- Reset values:
  - `sdo`, `reg_wr`, `frame_err` and `busy` = 0.
  - `reg_addr` = 0 and `reg_wdata` = 0.
  - Registers = `RESET_VALUES`, so `rx_gain` = `RESET_VALUES`[0x0A][5:0].
  - FSM = IDLE.
- Reset mid-frame discards the partial frame immediately. The next frame after release is decoded normally.

## Structure
- `ad9866_pkg` holds:
  - the FSM state enum;
  - `AD9866_REG_RESET` (bit [0:19][7:0], all 0x00 except 0x0A = 0x00 and 0x00 = 0x80);
  - the address constant `AD9866_ADDR_RXGAIN` = 0x0A;
  - the R/W bit-position constants.
- One sub-module: `ad9866_regfile`, with a synchronous write port, an asynchronous read port and a per-address reset from the parameter.
- Serial, FSM and abort logic live in the top module.

## Test plan
- Write 0x07=0x21 (frame 0x0721) → `reg_wr` pulse, `reg_addr`=0x07, `reg_wdata`=0x21; a readback (0x8700) gives `sdo` bits 7:0 = 0x21.
- Write 0x0A=0x2A, then read 0x8A00 → `rx_gain`=0x2A; initiator `dataout`=0x2A; `sdo` = 0 during the first 8 bits.
- `sen_n` raised after 10 rising edges of frame 0x0B20 → `frame_err` pulse, no `reg_wr`, register 0x0B unchanged.
- Write 0x1F=0x55, then read 0x9F00 → no `reg_wr`; read data 0x00.
- Assert `reset_n` low after 5 bits, release, then write 0x0C=0x41 → all outputs at reset values during reset; the later write commits correctly.
- Connect the existing AD9866 configuration initiator with `extrqst`=1 and `gain`=0x15 → regs 0x00, 0x07, 0x08, 0x0B, 0x0C, 0x0D and 0x11 hold 0x80, 0x21, 0x4B, 0x20, 0x41, 0x01 and 0x00; `rx_gain`=0x15; no `frame_err`.
